// File: rtl/nibble_serial_addsub_if.sv
// Request/result bundle for nibble_serial_addsub: operands and start in,
// busy/done handshake plus registered result and flags out.
interface nibble_serial_addsub_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, s, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, s, cout, ovf
  );
endinterface

// File: rtl/nibble_serial_addsub.sv
// Wide add/subtract computed one nibble per clock through a 4-bit add/sub slice.
// Optional signed saturation on overflow: define NIBBLE_ADDSUB_SAT_EN.
module nibble_serial_addsub #(
  parameter int NIBBLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  nibble_serial_addsub_if.slave   bus
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-5:0]     r_acc;
  logic [W-1:0]     r_s;
  logic             r_cout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic [5:0]       w_slice;
  logic [3:0]       w_sum;
  logic             w_c3;
  logic             w_c4;
  logic [W-1:0]     w_result;
  logic [W-1:0]     w_final;

  // 4-bit ripple slice; returns {carry out, carry into bit 3, sum[3:0]}.
  function automatic logic [5:0] slice4(input logic [3:0] x, input logic [3:0] y,
                                        input logic ci);
    logic [3:0] lo;
    logic       s3;
    logic       c4;
    lo = {1'b0, x[2:0]} + {1'b0, y[2:0]} + {3'b000, ci};
    s3 = x[3] ^ y[3] ^ lo[3];
    c4 = (x[3] & y[3]) | (lo[3] & (x[3] ^ y[3]));
    return {c4, lo[3], s3, lo[2:0]};
  endfunction

`ifdef NIBBLE_ADDSUB_SAT_EN
  function automatic logic [W-1:0] sat_result(input logic [W-1:0] sum,
                                              input logic ovf, input logic a_msb);
    logic signed [W-1:0] max_v;
    logic signed [W-1:0] min_v;
    max_v = {1'b0, {(W-1){1'b1}}};
    min_v = {1'b1, {(W-1){1'b0}}};
    if (!ovf)
      return sum;
    return a_msb ? min_v : max_v;
  endfunction
`endif

  assign w_accept = ((r_state == IDLE) || (r_state == DONE)) && bus.start;
  assign w_last   = (r_state == RUN) && (r_idx == LAST_IDX);

  assign w_slice  = slice4(r_a[3:0], r_b[3:0], r_carry);
  assign w_sum    = w_slice[3:0];
  assign w_c3     = w_slice[4];
  assign w_c4     = w_slice[5];
  assign w_result = {w_sum, r_acc};

  // Operands shift right each cycle, so r_a[3] is A's sign bit on the last nibble.
`ifdef NIBBLE_ADDSUB_SAT_EN
  assign w_final = sat_result(w_result, w_c3 ^ w_c4, r_a[3]);
`else
  assign w_final = w_result;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.start) w_next = RUN;
      RUN:     if (r_idx == LAST_IDX) w_next = DONE;
      DONE:    w_next = bus.start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_idx   <= '0;
      r_carry <= bus.sub;
    end else if (r_state == RUN) begin
      r_idx   <= r_idx + IDX_W'(1);
      r_carry <= w_c4;
      if (w_last) begin
        r_s    <= w_final;
        r_cout <= w_c4;
        r_ovf  <= w_c3 ^ w_c4;
      end
    end
  end

  // Working operands and partial sum carry no reset; they are loaded on accept.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= bus.a;
      r_b <= bus.b ^ {W{bus.sub}};
    end else if (r_state == RUN) begin
      r_a   <= r_a >> 4;
      r_b   <= r_b >> 4;
      r_acc <= (W-4)'({w_sum, r_acc} >> 4);
    end
  end

  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == DONE);
  assign bus.s    = r_s;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Testbench for nibble_serial_addsub (NIBBLES=4): vector table, random vectors
// against a full-width model, and handshake / reset corner sequences.
module tb_nibble_serial_addsub;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nibble_serial_addsub_if #(.NIBBLES(4)) bus ();

  nibble_serial_addsub #(.NIBBLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] s_wrap;
    logic [15:0] s_sat;
    logic        cout;
    logic        ovf;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[9];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  function automatic exp_t model(input logic sb, input logic [15:0] aa, input logic [15:0] bb);
    exp_t        e;
    logic [15:0] bp;
    logic [16:0] sum;
    bp     = sb ? ~bb : bb;
    sum    = {1'b0, aa} + {1'b0, bp} + {16'h0000, sb};
    e.s    = sum[15:0];
    e.cout = sum[16];
    e.ovf  = (aa[15] == bp[15]) && (sum[15] != aa[15]);
`ifdef NIBBLE_ADDSUB_SAT_EN
    if (e.ovf) e.s = aa[15] ? 16'h8000 : 16'h7FFF;
`endif
    return e;
  endfunction

  task automatic wait_done(input int maxc, output int n, output int bc);
    n  = 0;
    bc = 0;
    while (bus.done !== 1'b1 && n < maxc) begin
      if (bus.busy === 1'b1) bc++;
      @(negedge clk);
      n++;
    end
    chk("done_seen", {31'd0, bus.done}, 32'd1);
  endtask

  task automatic pop_cmp(input string nm, output exp_t e);
    e = '{s: 16'h0, cout: 1'b0, ovf: 1'b0};
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL %s: got done with empty scoreboard, required queued result", nm);
    end else begin
      e = sb_q.pop_front();
      chk({nm, " s"},    bus.s,    e.s);
      chk({nm, " cout"}, bus.cout, e.cout);
      chk({nm, " ovf"},  bus.ovf,  e.ovf);
    end
  endtask

  task automatic do_op(input logic sb, input logic [15:0] aa, input logic [15:0] bb,
                       input exp_t e, input string nm);
    int   n;
    int   bc;
    exp_t got;
    @(negedge clk);
    bus.start = 1'b1; bus.sub = sb; bus.a = aa; bus.b = bb;
    sb_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0; bus.sub = 1'($urandom); bus.a = 16'($urandom); bus.b = 16'($urandom);
    wait_done(20, n, bc);
    chk({nm, " latency"}, n, 4);
    chk({nm, " busy_cycles"}, bc, 4);
    chk({nm, " busy_at_done"}, {31'd0, bus.busy}, 32'd0);
    pop_cmp(nm, got);
  endtask

  initial begin
    int   n;
    int   bc;
    int   dcnt;
    exp_t e;
    exp_t e1;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rs;

    tbl[0] = '{1'b0, 16'h0005, 16'h0003, 16'h0008, 16'h0008, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 16'h00FF, 16'h0001, 16'h0100, 16'h0100, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 16'h0005, 16'h0002, 16'h0003, 16'h0003, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 16'h0003, 16'hFFFD, 16'h0006, 16'h0006, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 16'h7FFF, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 16'h8000, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 16'h8000, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 16'h1234, 16'h4321, 16'h5555, 16'h5555, 1'b0, 1'b0};

    bus.start = 1'b0; bus.sub = 1'b0; bus.a = 16'h0; bus.b = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset done", {31'd0, bus.done}, 32'd0);
    chk("reset s",    bus.s, 32'd0);
    chk("reset cout", {31'd0, bus.cout}, 32'd0);
    chk("reset ovf",  {31'd0, bus.ovf},  32'd0);

    for (int i = 0; i < 9; i++) begin
`ifdef NIBBLE_ADDSUB_SAT_EN
      e.s = tbl[i].s_sat;
`else
      e.s = tbl[i].s_wrap;
`endif
      e.cout = tbl[i].cout;
      e.ovf  = tbl[i].ovf;
      do_op(tbl[i].sub, tbl[i].a, tbl[i].b, e, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
      do_op(rs, ra, rb, model(rs, ra, rb), $sformatf("rnd%0d", i));
    end

    // start pulsed during RUN must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.sub = 1'b0; bus.a = 16'h1111; bus.b = 16'h2222;
    sb_q.push_back(model(1'b0, 16'h1111, 16'h2222));
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'hAAAA; bus.b = 16'h5555; bus.sub = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(20, n, bc);
    chk("ign latency", n + 2, 4);
    pop_cmp("ign", e1);
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dcnt++;
    end
    chk("ign no_extra_done", dcnt, 0);

    // start held high: accepted again in the DONE cycle
    @(negedge clk);
    bus.start = 1'b1; bus.sub = 1'b0; bus.a = 16'h0F0F; bus.b = 16'h0101;
    sb_q.push_back(model(1'b0, 16'h0F0F, 16'h0101));
    @(negedge clk);
    bus.sub = 1'b1; bus.a = 16'h0100; bus.b = 16'h0200;
    wait_done(20, n, bc);
    chk("b2b first latency", n, 4);
    pop_cmp("b2b first", e1);
    sb_q.push_back(model(1'b1, 16'h0100, 16'h0200));
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b reaccept busy", {31'd0, bus.busy}, 32'd1);
    chk("b2b hold s", bus.s, e1.s);
    @(negedge clk);
    chk("b2b hold s mid", bus.s, e1.s);
    wait_done(20, n, bc);
    chk("b2b done spacing", n + 2, 5);
    pop_cmp("b2b second", e);

    // reset on the 2nd RUN edge aborts with no done
    @(negedge clk);
    bus.start = 1'b1; bus.sub = 1'b0; bus.a = 16'h1234; bus.b = 16'h1111;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", {31'd0, bus.busy}, 32'd0);
    chk("abort done", {31'd0, bus.done}, 32'd0);
    chk("abort s",    bus.s, 32'd0);
    chk("abort cout", {31'd0, bus.cout}, 32'd0);
    chk("abort ovf",  {31'd0, bus.ovf},  32'd0);
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) dcnt++;
    end
    chk("abort no_done", dcnt, 0);

    do_op(1'b0, 16'h0005, 16'h0003, model(1'b0, 16'h0005, 16'h0003), "post_reset");
    chk("scoreboard empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nibble_serial_addsub.md
# nibble_serial_addsub

Multi-cycle add/subtract engine that extends the team's 4-bit ripple-carry add/sub slice to wide operands. It streams one nibble per clock through an internal 4-bit add/sub slice and registers the carry between nibbles. It sits directly upstream of the 4-bit adder and drives its A/B/Cin each cycle. It also consumes that slice's S/Cout, assembling them into a full-width result with carry and signed-overflow flags.

## Interface
- NIBBLES, 4, operand width in nibbles; W = 4*NIBBLES; legal range 2..16
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when state is IDLE or DONE
- sub  input  1  0 = A+B, 1 = A−B (two's complement: B inverted, initial carry = 1)
- a  input  W  operand A, captured on accepted start
- b  input  W  operand B, captured on accepted start
- busy  output  1  high while state is RUN
- done  output  1  one-cycle pulse, high while state is DONE
- s  output  W  registered result
- cout  output  1  carry out of MSB; for subtraction 1 = no borrow
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE: if start=1, latch a, b^{W{sub}}, carry ← sub, idx ← 0, go to RUN; else stay.
- RUN: each cycle adds nibble idx of A, B′ and the carry through the 4-bit slice, writes the 4-bit sum into nibble idx of the working register and updates carry.
  - On the last nibble (idx = NIBBLES−1), the carry into bit 3 of the slice is captured for ovf.
  - The idx = NIBBLES−1 cycle loads s, cout and ovf from the working state and goes to DONE.
  - Otherwise idx ← idx+1.
- DONE: done=1 for exactly one cycle.
  - If start=1 in this cycle, a new operation is accepted as from IDLE and the next state is RUN.
  - Otherwise the next state is IDLE.
- start while in RUN is ignored; there is no queueing.
- a, b and sub are don't-care except on the accepting edge.
- s, cout and ovf change only on the edge entering DONE. They hold the last result until the next completion, including during RUN of a later operation.
- Arithmetic is modulo 2^W: cout = bit W of A + B′ + sub.

## Timing
- Reset (rst=1 at an edge): state → IDLE, idx → 0, carry → 0, s → 0, cout → 0, ovf → 0, busy → 0, done → 0.
  - This applies in any state; mid-RUN reset aborts the operation and no done is produced.
  - rst has priority over start on the same edge.
- Latency: start accepted at edge k, so busy is high after edge k. The final nibble is processed at edge k+NIBBLES, and done/s are valid in the cycle after edge k+NIBBLES.
- busy is high for exactly NIBBLES cycles per operation.
- Throughput: back-to-back operations (start held high) complete every NIBBLES+1 cycles.
- done and busy are never high simultaneously.

## Configuration
- Macro NIBBLE_ADDSUB_SAT_EN controls signed saturation on overflow.
- Defined: if ovf=1 on completion, s is loaded with the saturated value instead of the wrapped sum.
  - A[W−1]=0 gives 0x7F…F.
  - A[W−1]=1 gives 0x80…0.
  - cout and ovf are reported unchanged.
- Undefined: s is always the wrapped modulo-2^W result.
- Latency and handshake are identical in both builds.

## Test plan
All scenarios use NIBBLES=4 (W=16).
- Basic add: sub=0, 0x0005 + 0x0003 → s=0x0008, cout=0, ovf=0; done exactly 4 edges after the accepting edge; busy high for 4 cycles.
- Inter-nibble carry: 0x00FF + 0x0001 → 0x0100, cout=0. Also 0xFFFF + 0x0001 → 0x0000, cout=1, ovf=0.
- Subtract: 0x0005 − 0x0002 → 0x0003, cout=1. Also 0x0003 − 0xFFFD (−3) → 0x0006, cout=0, ovf=0.
- Overflow, 0x7FFF + 0x0001 → ovf=1, cout=0:
  - s=0x8000 without the macro, 0x7FFF with NIBBLE_ADDSUB_SAT_EN.
- Overflow, 0x8000 − 0x0001 → ovf=1, cout=1:
  - s=0x7FFF without the macro, 0x8000 with NIBBLE_ADDSUB_SAT_EN.
- Handshake: start pulsed during RUN is ignored and the result is unchanged. start held high through DONE is accepted and gives a second done 5 cycles after the first. s holds the first result until the second done.
- Reset mid-run: rst=1 on the 2nd RUN edge → next cycle state IDLE, busy=0, s=0, cout=0, ovf=0, and no done pulse follows.
